multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle main control FSM for the LEGv8 datapath. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives the `aluop` code that `aludec` consumes, plus every datapath enable and mux select. It sits between the instruction register opcode field and the shared datapath, replacing the single-cycle `maindec`.

## Interface
Parameters:
- none; opcodes and state encodings come from the shared package.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Op` in 11: IR[31:21], valid from DECODE onward.
- `Zero` in 1: ALU zero flag, combinational from the current ALU operation.
- `aluop` out 2: 00 add, 01 pass-B/compare (CBZ), 10 funct-decoded.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by `Zero` in the datapath.
- `IRWrite` out 1: IR load.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write.
- `MemtoReg` out 1: 1 = MDR, 0 = ALUOut.
- `Reg2Loc` out 1: 1 = Rt field, 0 = Rm field.
- `ALUSrcA` out 1: 0 = PC, 1 = register A.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `PCSrc` out 1: 0 = ALU result, 1 = ALUOut.
- `IllegalOp` out 1: one-cycle pulse on an unrecognised opcode.
- `State` out 4: current state, for debug.

## Operation
- **States:** IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH.
- **IDLE:** all outputs 0. Next state is FETCH.
- **FETCH:** MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, aluop=00, PCWrite=1, PCSrc=0. Next state is DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, aluop=00, Reg2Loc=1 if Op is STUR or CBZ, else 0. This precomputes the branch target into ALUOut.
  - LDUR (11111000010) or STUR (11111000000) → MEMADR.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXECUTE.
  - CBZ (Op[10:3]=10110100) → BRANCH.
  - Anything else → FETCH, with IllegalOp=1 during this DECODE cycle.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, aluop=00, Reg2Loc held from DECODE. Next state is MEMREAD for LDUR, MEMWRITE for STUR.
- **MEMREAD:** MemRead=1. Next state is MEMWB.
- **MEMWB:** RegWrite=1, MemtoReg=1. Next state is FETCH.
- **MEMWRITE:** MemWrite=1, Reg2Loc=1. Next state is FETCH.
- **EXECUTE:** ALUSrcA=1, ALUSrcB=00, aluop=10, Reg2Loc=0. Next state is ALUWB.
- **ALUWB:** RegWrite=1, MemtoReg=0. Next state is FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, aluop=01, Reg2Loc=1, PCWriteCond=1, PCSrc=1. Next state is FETCH regardless of `Zero`.
- **Output defaults:** any output not listed for a state is 0. All outputs are Moore, decoded from the state register, except IllegalOp and the DECODE next-state choice, which depend on `Op`.
- **Opcode compare:** exact 11-bit compare; CBZ compares 8 bits only.

## Timing
- **Reset:** asserting `reset` forces IDLE immediately (asynchronous), with every output 0 and State=IDLE.
  - Reset mid-instruction aborts the instruction. No write strobe may be asserted in the cycle after reset asserts.
- **After reset deasserts:** the first rising edge moves to FETCH. The first instruction fetch therefore happens one cycle after release.
- **Cycles per instruction:** LDUR 5, STUR 4, R-type 4, CBZ 3, illegal 2 (FETCH + DECODE).
- **Write strobes:** MemWrite, RegWrite, PCWrite and IRWrite are each high for exactly one cycle per instruction in the states listed above.
- **Op stability:** `Op` is sampled only in DECODE and MEMADR. Changes at any other time have no effect.
- **Zero:** the FSM never samples `Zero`; it is consumed in the datapath with PCWriteCond.

## Structure
- **Package `legv8_pkg`:**
  - `state_t` enum (4-bit encoding, IDLE=0).
  - `localparam` opcode constants: OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ_PREFIX.
  - ALUOP_ADD/ALUOP_CBZ/ALUOP_FUNCT codes, shared with `aludec`.
- **Sub-module `opclass`:** combinational; maps `Op` to {mem_ld, mem_st, rtype, cbz, illegal}. Used by both the DECODE transition and the Reg2Loc decode.
- **Implementation:** one `always_ff` state register with asynchronous reset, one `always_comb` for next state, one `always_comb` for outputs.

## Test plan
- **Reset:** hold reset 3 cycles with Op=ADD → all outputs 0, State=IDLE. Release → FETCH next edge, with PCWrite=1, IRWrite=1, ALUSrcB=01.
- **ADD:** Op=10001011000 → states FETCH, DECODE, EXECUTE, ALUWB, FETCH. aluop=10 only in EXECUTE; RegWrite=1 only in ALUWB.
- **LDUR then STUR:** LDUR takes 5 cycles with MemtoReg=1 and RegWrite=1 in MEMWB. STUR takes 4 cycles with MemWrite=1 once and Reg2Loc=1.
- **CBZ:** Op=10110100101 → BRANCH with aluop=01, PCWriteCond=1, PCSrc=1. Back to FETCH with Zero=0 and with Zero=1.
- **Illegal:** Op=00000000000 → IllegalOp=1 for one DECODE cycle, then FETCH; no RegWrite or MemWrite asserted.
- **Reset mid-instruction:** assert reset asynchronously mid-cycle in MEMREAD → State=IDLE and MemRead=0 before the next edge; a clean fetch follows after release.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: state encoding, opcodes, ALU op codes.
package legv8_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [10:0] OP_LDUR       = 11'b11111000010;
  localparam logic [10:0] OP_STUR       = 11'b11111000000;
  localparam logic [10:0] OP_ADD        = 11'b10001011000;
  localparam logic [10:0] OP_SUB        = 11'b11001011000;
  localparam logic [10:0] OP_AND        = 11'b10001010000;
  localparam logic [10:0] OP_ORR        = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ_PREFIX = 8'b10110100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // One-hot-ish opcode classification; exactly one field is set.
  typedef struct packed {
    logic mem_ld;
    logic mem_st;
    logic rtype;
    logic cbz;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier: exact 11-bit match, CBZ on its 8-bit prefix.
module opclass
  import legv8_pkg::*;
(
  input  logic [10:0] op_i,
  output op_class_t   cls_o
);

  // Classify the IR opcode field into the instruction groups the FSM needs.
  always_comb begin
    cls_o        = '0;
    cls_o.mem_ld = (op_i == OP_LDUR);
    cls_o.mem_st = (op_i == OP_STUR);
    cls_o.rtype  = (op_i == OP_ADD) || (op_i == OP_SUB) ||
                   (op_i == OP_AND) || (op_i == OP_ORR);
    cls_o.cbz    = (op_i[10:3] == OP_CBZ_PREFIX);
    cls_o.illegal = !(cls_o.mem_ld || cls_o.mem_st || cls_o.rtype || cls_o.cbz);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 main control FSM: Moore datapath controls per state,
// with the opcode consulted only in DECODE and MEMADR.
module multicycle_ctrl
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  output logic [1:0]  aluop,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        PCSrc,
  output logic        IllegalOp,
  output logic [3:0]  State
);

  state_t    state_q, state_d;
  op_class_t cls;

  // Zero is qualified with PCWriteCond in the datapath, never in here.
  logic unused_zero;
  assign unused_zero = Zero;

  opclass u_opclass (
    .op_i  (Op),
    .cls_o (cls)
  );

  assign State = state_q;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (cls.mem_ld || cls.mem_st) state_d = S_MEMADR;
        else if (cls.rtype)           state_d = S_EXECUTE;
        else if (cls.cbz)             state_d = S_BRANCH;
        else                          state_d = S_FETCH;
      end
      // A load/store opcode was latched through DECODE; anything else is
      // an unstable IR and falls back to a fresh fetch.
      S_MEMADR: begin
        if (cls.mem_ld)      state_d = S_MEMREAD;
        else if (cls.mem_st) state_d = S_MEMWRITE;
        else                 state_d = S_FETCH;
      end
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; everything not listed is 0.
  always_comb begin
    aluop       = ALUOP_ADD;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 1'b0;
    IllegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      // Branch target PC + (imm<<2) is precomputed here into ALUOut.
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        Reg2Loc   = cls.mem_st || cls.cbz;
        IllegalOp = cls.illegal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = cls.mem_st;
      end
      S_MEMREAD:  MemRead = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        aluop       = ALUOP_CBZ;
        Reg2Loc     = 1'b1;
        PCWriteCond = 1'b1;
        PCSrc       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle against hand-written state/control vectors.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] Op;
  logic        Zero;
  logic [1:0]  aluop;
  logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite;
  logic        MemtoReg, Reg2Loc, ALUSrcA, PCSrc, IllegalOp;
  logic [1:0]  ALUSrcB;
  logic [3:0]  State;

  int checks;
  int failures;

  // State encodings and opcodes written out by hand.
  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_MEMADR = 4'd3, ST_MEMREAD = 4'd4, ST_MEMWB = 4'd5,
                         ST_MEMWRITE = 4'd6, ST_EXECUTE = 4'd7, ST_ALUWB = 4'd8,
                         ST_BRANCH = 4'd9;

  // Control vector layout:
  // {aluop[1:0], PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
  //  MemtoReg, Reg2Loc, ALUSrcA, ALUSrcB[1:0], PCSrc, IllegalOp}
  localparam logic [14:0] C_ZERO    = 15'b00_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [14:0] C_FETCH   = 15'b00_1_0_1_1_0_0_0_0_0_01_0_0;
  localparam logic [14:0] C_DEC     = 15'b00_0_0_0_0_0_0_0_0_0_11_0_0;
  localparam logic [14:0] C_DEC_R2L = 15'b00_0_0_0_0_0_0_0_1_0_11_0_0;
  localparam logic [14:0] C_DEC_ILL = 15'b00_0_0_0_0_0_0_0_0_0_11_0_1;
  localparam logic [14:0] C_MA_LD   = 15'b00_0_0_0_0_0_0_0_0_1_10_0_0;
  localparam logic [14:0] C_MA_ST   = 15'b00_0_0_0_0_0_0_0_1_1_10_0_0;
  localparam logic [14:0] C_MEMRD   = 15'b00_0_0_0_1_0_0_0_0_0_00_0_0;
  localparam logic [14:0] C_MEMWB   = 15'b00_0_0_0_0_0_1_1_0_0_00_0_0;
  localparam logic [14:0] C_MEMWR   = 15'b00_0_0_0_0_1_0_0_1_0_00_0_0;
  localparam logic [14:0] C_EXEC    = 15'b10_0_0_0_0_0_0_0_0_1_00_0_0;
  localparam logic [14:0] C_ALUWB   = 15'b00_0_0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [14:0] C_BRANCH  = 15'b01_0_1_0_0_0_0_0_1_1_00_1_0;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .Op          (Op),
    .Zero        (Zero),
    .aluop       (aluop),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .Reg2Loc     (Reg2Loc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSrc       (PCSrc),
    .IllegalOp   (IllegalOp),
    .State       (State)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_now();
    return {aluop, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
            MemtoReg, Reg2Loc, ALUSrcA, ALUSrcB, PCSrc, IllegalOp};
  endfunction

  task automatic expect_now(input string tag, input logic [3:0] st, input logic [14:0] c);
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".ctrl"}, {17'd0, ctrl_now()}, {17'd0, c});
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Op       = 11'b10001011000; // ADD held during reset
    Zero     = 1'b0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_now($sformatf("reset%0d", i), ST_IDLE, C_ZERO);
    end
    reset = 1'b0;
    tick();
    expect_now("rel_fetch", ST_FETCH, C_FETCH);

    // ADD: FETCH DECODE EXECUTE ALUWB FETCH. Op disturbed in EXECUTE has no effect.
    tick(); expect_now("add_dec", ST_DECODE, C_DEC);
    tick(); expect_now("add_exe", ST_EXECUTE, C_EXEC);
    Op = 11'b00000000000;
    tick(); expect_now("add_wb", ST_ALUWB, C_ALUWB);
    tick(); expect_now("add_fetch", ST_FETCH, C_FETCH);

    // LDUR: 5 cycles.
    Op = 11'b11111000010;
    tick(); expect_now("ld_dec", ST_DECODE, C_DEC);
    tick(); expect_now("ld_adr", ST_MEMADR, C_MA_LD);
    tick(); expect_now("ld_rd", ST_MEMREAD, C_MEMRD);
    tick(); expect_now("ld_wb", ST_MEMWB, C_MEMWB);
    tick(); expect_now("ld_fetch", ST_FETCH, C_FETCH);

    // STUR: 4 cycles.
    Op = 11'b11111000000;
    tick(); expect_now("st_dec", ST_DECODE, C_DEC_R2L);
    tick(); expect_now("st_adr", ST_MEMADR, C_MA_ST);
    tick(); expect_now("st_wr", ST_MEMWRITE, C_MEMWR);
    tick(); expect_now("st_fetch", ST_FETCH, C_FETCH);

    // CBZ with low register bits set, Zero=0 then Zero=1.
    for (int z = 0; z < 2; z++) begin
      Op   = 11'b10110100101;
      Zero = (z == 1);
      tick(); expect_now($sformatf("cbz%0d_dec", z), ST_DECODE, C_DEC_R2L);
      tick(); expect_now($sformatf("cbz%0d_br", z), ST_BRANCH, C_BRANCH);
      tick(); expect_now($sformatf("cbz%0d_fetch", z), ST_FETCH, C_FETCH);
    end
    Zero = 1'b0;

    // SUB / AND / ORR all take the R-type path.
    Op = 11'b11001011000;
    tick(); expect_now("sub_dec", ST_DECODE, C_DEC);
    tick(); expect_now("sub_exe", ST_EXECUTE, C_EXEC);
    tick(); tick();
    Op = 11'b10101010000;
    tick(); expect_now("orr_dec", ST_DECODE, C_DEC);
    tick(); expect_now("orr_exe", ST_EXECUTE, C_EXEC);
    tick(); tick();

    // Illegal opcode, plus a near-miss of LDUR (one bit off).
    Op = 11'b00000000000;
    tick(); expect_now("ill_dec", ST_DECODE, C_DEC_ILL);
    tick(); expect_now("ill_fetch", ST_FETCH, C_FETCH);
    Op = 11'b11111000011;
    tick(); expect_now("ill2_dec", ST_DECODE, C_DEC_ILL);
    tick(); expect_now("ill2_fetch", ST_FETCH, C_FETCH);

    // Reset asserted mid-cycle in MEMREAD acts before the next edge.
    Op = 11'b11111000010;
    tick(); tick();
    tick(); expect_now("mid_rd", ST_MEMREAD, C_MEMRD);
    #2 reset = 1'b1;
    #1 expect_now("mid_async", ST_IDLE, C_ZERO);
    tick(); expect_now("mid_hold", ST_IDLE, C_ZERO);
    reset = 1'b0;
    Op = 11'b10001011000;
    tick(); expect_now("mid_fetch", ST_FETCH, C_FETCH);
    tick(); expect_now("mid_dec", ST_DECODE, C_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout: bench did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
